// File: rtl/mul_bcd_conv_if.sv
// Handshake and result bus between the multiplier stage and the BCD converter.
interface mul_bcd_conv_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] prod;
  logic             out_valid;
  logic             sign;
  logic [15:0]      bcd;

  modport master (output in_valid, prod, input in_ready, out_valid, sign, bcd);
  modport slave  (input in_valid, prod, output in_ready, out_valid, sign, bcd);
endinterface

// File: rtl/mul_bcd_conv.sv
// Signed product to sign + 4-digit BCD magnitude, one bit per cycle
// (shift-and-add-3). A result appears WIDTH cycles after accept and is
// held with out_valid until the next accept.
module mul_bcd_conv #(
  parameter int WIDTH = 12
) (
  input  logic             clk,
  input  logic             rst,
  mul_bcd_conv_if.slave    bus
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t           state_q, state_d;
  logic             rdy, accept, last;
  logic [WIDTH-1:0] mag, sh_q, nxt_sh;
  logic [15:0]      work_q, bcd_adj, nxt_work;
  logic [CW-1:0]    cnt_q;
  logic             sign_lat_q, sign_q;
  logic [15:0]      bcd_q;

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == DONE);
  assign bus.sign      = sign_q;
  assign bus.bcd       = bcd_q;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake; CONV is only entered by accept and left on the last shift.
  always_comb begin
    state_d = state_q;
    rdy     = (state_q != CONV);
    accept  = bus.in_valid && rdy;
    last    = (state_q == CONV) && (cnt_q == CW'(WIDTH - 1));
    case (state_q)
      IDLE, DONE: if (accept) state_d = CONV;
      CONV:       if (last)   state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Magnitude of the input; the most-negative value maps to 2^(WIDTH-1) as unsigned.
  always_comb begin
    mag = bus.prod[WIDTH-1] ? (~bus.prod + WIDTH'(1)) : bus.prod;
  end

  // One double-dabble step: +3 on digits >= 5 (4-bit, no inter-digit carry), then shift.
  always_comb begin
    bcd_adj = work_q;
    for (int i = 0; i < 4; i++) begin
      if (work_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = work_q[i*4 +: 4] + 4'd3;
    end
    nxt_work = {bcd_adj[14:0], sh_q[WIDTH-1]};
    nxt_sh   = {sh_q[WIDTH-2:0], 1'b0};
  end

  // Working registers and result; outputs only update when a conversion completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_q       <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      sign_lat_q <= 1'b0;
      sign_q     <= 1'b0;
      bcd_q      <= '0;
    end else if (accept) begin
      sign_lat_q <= bus.prod[WIDTH-1];
      sh_q       <= mag;
      work_q     <= '0;
      cnt_q      <= '0;
    end else if (state_q == CONV) begin
      sh_q   <= nxt_sh;
      work_q <= nxt_work;
      cnt_q  <= cnt_q + CW'(1);
      if (last) begin
        bcd_q  <= nxt_work;
        sign_q <= sign_lat_q;
      end
    end
  end
endmodule

// File: tb/tb_mul_bcd_conv.sv
// Directed bench for mul_bcd_conv: known vectors, mid-conversion
// interference, async reset abort, and all 6-bit x 6-bit products.
module tb_mul_bcd_conv;
  localparam int WIDTH = 12;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   lat, lat0, p, m;
  logic neg;

  mul_bcd_conv_if #(.WIDTH(WIDTH)) bus ();
  mul_bcd_conv #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Present a product for one accept edge; returns #1 after that edge.
  task automatic start(input logic [WIDTH-1:0] v);
    @(negedge clk);
    bus.prod     = v;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  // Count edges until out_valid, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.prod     = '0;
    rst          = 1'b1;
    #12;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready),  32'd1);
    check("rst_sign",      32'(bus.sign),      32'd0);
    check("rst_bcd",       32'(bus.bcd),       32'h0000);
    @(negedge clk);
    rst = 1'b0;

    // +1024 with latency check
    start(12'h400);
    check("conv_in_ready", 32'(bus.in_ready), 32'd0);
    wait_done(lat);
    check("lat_1024",  32'(lat), 32'd12);
    check("sign_1024", 32'(bus.sign), 32'd0);
    check("bcd_1024",  32'(bus.bcd), 32'h1024);

    start(12'hC20); wait_done(lat);
    check("lat_m992", 32'(lat), 32'd12);
    check("res_m992", {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b1, 16'h0992});
    start(12'h000); wait_done(lat);
    check("res_zero", {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b0, 16'h0000});
    start(12'h800); wait_done(lat);
    check("res_min",  {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b1, 16'h2048});
    check("done_in_ready", 32'(bus.in_ready), 32'd1);

    // +63 with a stray in_valid pulse mid-conversion
    start(12'h03F);
    repeat (4) @(posedge clk);
    @(negedge clk);
    bus.prod     = 12'h001;
    bus.in_valid = 1'b1;
    check("mid_in_ready",  32'(bus.in_ready),  32'd0);
    check("mid_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_hold",      {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b1, 16'h2048});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    wait_done(lat0);
    check("lat_63", 32'(lat0 + 5), 32'd12);
    check("res_63", {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b0, 16'h0063});

    // +993 aborted by reset mid-conversion
    start(12'h3E1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_out_valid", 32'(bus.out_valid), 32'd0);
    check("abort_bcd",       32'(bus.bcd),       32'h0000);
    check("abort_sign",      32'(bus.sign),      32'd0);
    check("abort_in_ready",  32'(bus.in_ready),  32'd1);
    @(negedge clk);
    rst = 1'b0;
    start(12'hFFF); wait_done(lat);
    check("lat_m1", 32'(lat), 32'd12);
    check("res_m1", {15'b0, bus.sign, bus.bcd}, {15'b0, 1'b1, 16'h0001});

    // All signed 6-bit products, back-to-back accepts in DONE
    for (int x = -32; x < 32; x++) begin
      for (int y = -32; y < 32; y++) begin
        p   = x * y;
        neg = (p < 0);
        m   = neg ? -p : p;
        start(12'(p));
        wait_done(lat);
        check("exh", {15'b0, bus.sign, bus.bcd}, {15'b0, neg, to_bcd(m)});
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
